// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types and constants for the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TOUT = 2'd2
    } arb_state_t;

    // Bank IDs decoded downstream from the shared bus address.
    localparam logic [7:0]  BNK_RAM   = 8'h00;
    localparam logic [7:0]  BNK_LED   = 8'h01;
    localparam logic [7:0]  BNK_VIDEO = 8'h02;

    // Read data handed back on a timed-out transfer.
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : bus_watchdog
// Description : Counts stalled cycles of a granted transfer, flags expiry and
//               registers the timeout pulse plus the offending address.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_active,       // granted transfer in flight, stb high
    input  logic        i_ack,          // slave ack this cycle
    input  logic [31:0] i_adr,          // granted address
    output logic        o_expire,       // last stalled cycle: force completion
    output logic        o_timeout,      // high during the forced-completion cycle
    output logic [31:0] o_timeout_adr
);

    localparam int unsigned    CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  c_LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   tadr_q, tadr_d;
    logic          w_expire;

    // A real ack always beats expiry on the same cycle; TIMEOUT of 0 never expires.
    assign w_expire = (TIMEOUT != 0) && i_active && !i_ack && (cnt_q == c_LAST_CNT);

    // Counter runs only while stalled, so it is zero on every entry to BUSY.
    always_comb begin
        cnt_d     = '0;
        timeout_d = w_expire;
        tadr_d    = tadr_q;
        if (i_active && !i_ack && !w_expire) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (w_expire) begin
            tadr_d = i_adr;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            tadr_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            tadr_q    <= tadr_d;
        end
    end

    assign o_expire      = w_expire;
    assign o_timeout     = timeout_q;
    assign o_timeout_adr = tadr_q;

endmodule : bus_watchdog
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter sharing the CPU-side memory bus between
//               the CPU (m0) and the DMA/blitter (m1), with a stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        timeout_o,
    output logic [31:0] timeout_adr_o,
    output logic [1:0]  grant_o
);

    arb_state_t  state_q, state_d;
    logic [1:0]  grant_q, grant_d;   // one-hot: [0]=m0, [1]=m1
    logic        prio_q, prio_d;     // 0: m0 wins a tie, 1: m1 wins a tie

    logic        w_busy, w_tout, w_gnt_stb, w_active, w_ack_ok, w_expire;

    assign w_busy    = (state_q == ST_BUSY);
    assign w_tout    = (state_q == ST_TOUT);
    assign w_gnt_stb = (grant_q[0] & m0_stb_i) | (grant_q[1] & m1_stb_i);
    assign w_active  = w_busy & w_gnt_stb;
    assign w_ack_ok  = w_active & s_ack_i;

    // Shared-bus and master-return muxing, all driven from the registered grant.
    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (w_busy) begin
            s_stb_o = w_gnt_stb;
            if (grant_q[1]) begin
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = w_ack_ok;
                m1_dat_o = s_dat_i;
            end else if (grant_q[0]) begin
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = w_ack_ok;
                m0_dat_o = s_dat_i;
            end
        end else if (w_tout) begin
            // Forced completion: error word back, any write is dropped.
            m0_ack_o = grant_q[0];
            m1_ack_o = grant_q[1];
            m0_dat_o = grant_q[0] ? ERR_DATA : '0;
            m1_dat_o = grant_q[1] ? ERR_DATA : '0;
        end
    end

    // Next-state logic: arbitrate in IDLE, complete or abandon in BUSY/TOUT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    grant_d = prio_q ? 2'b10 : 2'b01;
                end else if (m0_stb_i) begin
                    grant_d = 2'b01;
                end else if (m1_stb_i) begin
                    grant_d = 2'b10;
                end else begin
                    grant_d = 2'b00;
                end
                state_d = (m0_stb_i || m1_stb_i) ? ST_BUSY : ST_IDLE;
            end
            ST_BUSY: begin
                if (!w_gnt_stb) begin
                    // Master withdrew its request: abandon, keep priority.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (s_ack_i) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    prio_d  = grant_q[0];   // favour the master not just served
                end else if (w_expire) begin
                    state_d = ST_TOUT;
                end
            end
            ST_TOUT: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                prio_d  = grant_q[0];
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Arbiter state registers; reset drops the bus strobe without a clock.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    assign grant_o = grant_q;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst_i),
        .i_active      (w_active),
        .i_ack         (s_ack_i),
        .i_adr         (s_adr_o),
        .o_expire      (w_expire),
        .o_timeout     (timeout_o),
        .o_timeout_adr (timeout_adr_o)
    );

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
    logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic        timeout_o;
    logic [31:0] timeout_adr_o;
    logic [1:0]  grant_o;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    bus_arbiter #(.TIMEOUT(64), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst_i(rst_i),
        .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
        .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
        .m0_sel_i(m0_sel_i), .m1_sel_i(m1_sel_i),
        .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
        .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .timeout_o(timeout_o), .timeout_adr_o(timeout_adr_o),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_stb_i = 0; m1_stb_i = 0; m0_we_i = 0; m1_we_i = 0;
        m0_adr_i = 0; m1_adr_i = 0; m0_dat_i = 0; m1_dat_i = 0;
        m0_sel_i = 0; m1_sel_i = 0; s_ack_i = 0; s_dat_i = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1;
        step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        step();
        step();
        chk_cnt++;
        if ({grant_o, s_stb_o, s_we_o} !== 4'b0000) $display("FAIL reset_grant_stb: got %b want 0000", {grant_o, s_stb_o, s_we_o});
        else pass_cnt++;
        chk_cnt++;
        if ({s_adr_o, s_dat_o, s_sel_o} !== 68'h0) $display("FAIL reset_sbus: got adr=%h dat=%h sel=%h want 0", s_adr_o, s_dat_o, s_sel_o);
        else pass_cnt++;
        chk_cnt++;
        if ({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o} !== 66'h0) $display("FAIL reset_master: got ack=%b%b dat0=%h dat1=%h want 0", m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o);
        else pass_cnt++;
        chk_cnt++;
        if ({timeout_o, timeout_adr_o} !== 33'h0) $display("FAIL reset_timeout: got %b %h want 0", timeout_o, timeout_adr_o);
        else pass_cnt++;
        rst_i = 0;
    endtask

    task automatic test_single();
        m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0010; m0_sel_i = 4'hF;
        step();
        chk_cnt++;
        if (grant_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 32'h10) $display("FAIL single_grant: got g=%b stb=%b adr=%h want 01 1 00000010", grant_o, s_stb_o, s_adr_o);
        else pass_cnt++;
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        #1;
        chk_cnt++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678) $display("FAIL single_ack: got ack=%b dat=%h want 1 12345678", m0_ack_o, m0_dat_o);
        else pass_cnt++;
        chk_cnt++;
        if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) $display("FAIL single_other: got ack=%b dat=%h want 0 0", m1_ack_o, m1_dat_o);
        else pass_cnt++;
        step();
        m0_stb_i = 0; s_ack_i = 0;
        chk_cnt++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) $display("FAIL single_release: got g=%b stb=%b want 00 0", grant_o, s_stb_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h0000_0100; m0_dat_i = 32'hA5A5_A5A5; m0_sel_i = 4'hF;
        m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0100_0004; m1_dat_i = 32'h5A5A_5A5A; m1_sel_i = 4'h3;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_adr, exp_dat, rd;
            logic        exp_we;
            logic [3:0]  exp_sel;
            exp_adr = exp_g[i][0] ? 32'h0000_0100 : 32'h0100_0004;
            exp_dat = exp_g[i][0] ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
            exp_we  = exp_g[i][0];
            exp_sel = exp_g[i][0] ? 4'hF : 4'h3;
            step();
            chk_cnt++;
            if (grant_o !== exp_g[i] || s_stb_o !== 1'b1 || s_adr_o !== exp_adr || s_we_o !== exp_we || s_dat_o !== exp_dat || s_sel_o !== exp_sel)
                $display("FAIL b2b_grant%0d: got g=%b stb=%b adr=%h we=%b dat=%h sel=%h want g=%b stb=1 adr=%h we=%b dat=%h sel=%h",
                         i, grant_o, s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o, exp_g[i], exp_adr, exp_we, exp_dat, exp_sel);
            else pass_cnt++;
            s_ack_i = 1; s_dat_i = 32'h0000_1000 + i;
            #1;
            rd = exp_g[i][0] ? m0_dat_o : m1_dat_o;
            chk_cnt++;
            if ({m1_ack_o, m0_ack_o} !== exp_g[i] || rd !== 32'h0000_1000 + i || (exp_g[i][0] ? m1_dat_o : m0_dat_o) !== 32'h0)
                $display("FAIL b2b_ack%0d: got ack=%b%b owner_dat=%h want ack=%b owner_dat=%h", i, m1_ack_o, m0_ack_o, rd, exp_g[i], 32'h0000_1000 + i);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0)
                $display("FAIL b2b_dead%0d: got g=%b stb=%b ack=%b%b want 00 0 00", i, grant_o, s_stb_o, m1_ack_o, m0_ack_o);
            else pass_cnt++;
            s_ack_i = 0;
        end
        m0_stb_i = 0; m1_stb_i = 0; m0_we_i = 0;
    endtask

    task automatic test_timeout();
        int bad = 0;
        m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0500_0000; m1_sel_i = 4'hF;
        step();
        chk_cnt++;
        if (grant_o !== 2'b10 || s_stb_o !== 1'b1) $display("FAIL tout_grant: got g=%b stb=%b want 10 1", grant_o, s_stb_o);
        else pass_cnt++;
        for (int k = 1; k < 64; k++) begin
            step();
            if (s_stb_o !== 1'b1 || timeout_o !== 1'b0 || m1_ack_o !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL tout_busy_hold: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (s_stb_o !== 1'b0 || m1_ack_o !== 1'b1 || m1_dat_o !== 32'hDEAD_BEEF || m0_ack_o !== 1'b0)
            $display("FAIL tout_complete: got stb=%b ack1=%b dat1=%h ack0=%b want 0 1 deadbeef 0", s_stb_o, m1_ack_o, m1_dat_o, m0_ack_o);
        else pass_cnt++;
        chk_cnt++;
        if (timeout_o !== 1'b1 || timeout_adr_o !== 32'h0500_0000) $display("FAIL tout_flag: got %b %h want 1 05000000", timeout_o, timeout_adr_o);
        else pass_cnt++;
        step();
        m1_stb_i = 0;
        chk_cnt++;
        if (timeout_o !== 1'b0 || m1_ack_o !== 1'b0 || grant_o !== 2'b00 || timeout_adr_o !== 32'h0500_0000)
            $display("FAIL tout_after: got to=%b ack1=%b g=%b adr=%h want 0 0 00 05000000", timeout_o, m1_ack_o, grant_o, timeout_adr_o);
        else pass_cnt++;
    endtask

    task automatic test_ack_race();
        m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_0020;
        step();
        for (int k = 1; k < 64; k++) step();
        s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
        #1;
        chk_cnt++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hCAFE_F00D || s_stb_o !== 1'b1)
            $display("FAIL race_ack: got ack=%b dat=%h stb=%b want 1 cafef00d 1", m0_ack_o, m0_dat_o, s_stb_o);
        else pass_cnt++;
        step();
        s_ack_i = 0; m0_stb_i = 0;
        chk_cnt++;
        if (timeout_o !== 1'b0 || grant_o !== 2'b00 || m0_ack_o !== 1'b0 || timeout_adr_o !== 32'h0500_0000)
            $display("FAIL race_no_tout: got to=%b g=%b ack0=%b adr=%h want 0 00 0 05000000", timeout_o, grant_o, m0_ack_o, timeout_adr_o);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (timeout_o !== 1'b0) $display("FAIL race_no_tout_late: got %b want 0", timeout_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        m0_stb_i = 1; m0_adr_i = 32'h0000_0030;
        step();
        chk_cnt++;
        if (s_stb_o !== 1'b1 || grant_o !== 2'b01) $display("FAIL rstmid_busy: got stb=%b g=%b want 1 01", s_stb_o, grant_o);
        else pass_cnt++;
        #2 rst_i = 1;
        #1;
        chk_cnt++;
        if (s_stb_o !== 1'b0 || grant_o !== 2'b00 || m0_ack_o !== 1'b0)
            $display("FAIL rstmid_async: got stb=%b g=%b ack0=%b want 0 00 0", s_stb_o, grant_o, m0_ack_o);
        else pass_cnt++;
        m1_stb_i = 1;
        step();
        rst_i = 0;
        step();
        chk_cnt++;
        if (grant_o !== 2'b01) $display("FAIL rstmid_first_grant: got %b want 01", grant_o);
        else pass_cnt++;
        s_ack_i = 1;
        step();
        s_ack_i = 0; m0_stb_i = 0; m1_stb_i = 0;
    endtask

    task automatic test_stb_withdraw();
        m0_stb_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0200_0000;
        step();
        chk_cnt++;
        if (grant_o !== 2'b10) $display("FAIL withdraw_grant: got %b want 10", grant_o);
        else pass_cnt++;
        m1_stb_i = 0;
        #1;
        chk_cnt++;
        if (s_stb_o !== 1'b0 || m1_ack_o !== 1'b0) $display("FAIL withdraw_drop: got stb=%b ack1=%b want 0 0", s_stb_o, m1_ack_o);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (grant_o !== 2'b00 || m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0)
            $display("FAIL withdraw_idle: got g=%b ack=%b%b want 00 00", grant_o, m1_ack_o, m0_ack_o);
        else pass_cnt++;
        m1_stb_i = 1;
        step();
        chk_cnt++;
        if (grant_o !== 2'b10) $display("FAIL withdraw_prio_kept: got %b want 10", grant_o);
        else pass_cnt++;
        s_ack_i = 1; s_dat_i = 32'h0BAD_F00D;
        #1;
        chk_cnt++;
        if (m1_ack_o !== 1'b1 || m1_dat_o !== 32'h0BAD_F00D || m0_ack_o !== 1'b0)
            $display("FAIL withdraw_ack: got ack1=%b dat1=%h ack0=%b want 1 0badf00d 0", m1_ack_o, m1_dat_o, m0_ack_o);
        else pass_cnt++;
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ack_race();
        test_reset_mid();
        test_stb_withdraw();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
